// File: rtl/song_sequencer_pkg.sv
// Shared note codes, sequencer state encoding and the note-to-Led decode.
package song_sequencer_pkg;

   localparam logic [3:0] NOTE_NONE = 4'd0;
   localparam logic [3:0] NOTE_C4   = 4'd1;
   localparam logic [3:0] NOTE_D    = 4'd2;
   localparam logic [3:0] NOTE_E    = 4'd3;
   localparam logic [3:0] NOTE_F    = 4'd4;
   localparam logic [3:0] NOTE_G    = 4'd5;
   localparam logic [3:0] NOTE_A    = 4'd6;
   localparam logic [3:0] NOTE_B    = 4'd7;
   localparam logic [3:0] NOTE_C5   = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_GAP   = 2'd3
   } state_e;

   function automatic logic [7:0] note_to_led(input logic [3:0] n);
      logic [7:0] led;
      led = 8'h00;
      case (n)
         NOTE_C4: led = 8'h80;
         NOTE_D:  led = 8'h40;
         NOTE_E:  led = 8'h20;
         NOTE_F:  led = 8'h10;
         NOTE_G:  led = 8'h08;
         NOTE_A:  led = 8'h04;
         NOTE_B:  led = 8'h02;
         NOTE_C5: led = 8'h01;
         default: led = 8'h00;
      endcase
      return led;
   endfunction

   // Out-of-range codes (9..15) play as silence.
   function automatic logic [3:0] note_clean(input logic [3:0] n);
      return (n > NOTE_C5) ? NOTE_NONE : n;
   endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// Song table: step address to {note, duration}; duration 0 marks the end.
module song_rom
   import song_sequencer_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DUR_W  = 3
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [3:0]        note,
   output logic [DUR_W-1:0]  dur
);

   always_comb begin
      note = NOTE_NONE;
      dur  = '0;
      case (int'(addr))
         0: begin
            note = NOTE_C4;
            dur  = DUR_W'(2);
         end
         1: begin
            note = NOTE_E;
            dur  = DUR_W'(1);
         end
         default: begin
            note = NOTE_NONE;
            dur  = '0;
         end
      endcase
   end

endmodule

// File: rtl/song_sequencer.sv
// ROM-driven autoplay sequencer: FETCH/HOLD/GAP walk over the song table.
// Optional PAUSE input is enabled with SONG_SEQUENCER_PAUSE_EN.
module song_sequencer
   import song_sequencer_pkg::*;
#(
   parameter int SONG_LEN   = 32,
   parameter int ADDR_W     = 5,
   parameter int DUR_W      = 3,
   parameter int GAP_CYCLES = 1000000
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic              STOP,
   input  logic              LOOP,
   input  logic              QUARTER_BEAT,
`ifdef SONG_SEQUENCER_PAUSE_EN
   input  logic              PAUSE,
`endif
   output logic [3:0]        note,
   output logic [7:0]        Led,
   output logic              playing,
   output logic              done,
   output logic [ADDR_W-1:0] step
);

   localparam int GAP_W =
      (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] step_q, step_d;
   logic [3:0]        note_q, note_d;
   logic [DUR_W-1:0]  beat_q, beat_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              done_q, done_d;
   logic              frozen;
   logic [3:0]        rom_note;
   logic [DUR_W-1:0]  rom_dur;
   logic              song_end;

   song_rom #(
      .ADDR_W (ADDR_W),
      .DUR_W  (DUR_W)
   ) u_rom (
      .addr (step_q),
      .note (rom_note),
      .dur  (rom_dur)
   );

   assign song_end = (rom_dur == '0) ||
                     (int'(step_q) == SONG_LEN);

`ifdef SONG_SEQUENCER_PAUSE_EN
   logic paused_q, paused_d;

   always_comb begin
      paused_d = paused_q;
      if (PAUSE && state_q != S_IDLE)
         paused_d = ~paused_q;
      if (STOP || START || state_d == S_IDLE)
         paused_d = 1'b0;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) paused_q <= 1'b0;
      else       paused_q <= paused_d;
   end

   assign frozen = paused_q;
`else
   assign frozen = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      note_d  = note_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      if (STOP) begin
         state_d = S_IDLE;
         step_d  = '0;
         note_d  = NOTE_NONE;
         beat_d  = '0;
         gap_d   = '0;
      end else if (START) begin
         state_d = S_FETCH;
         step_d  = '0;
         note_d  = NOTE_NONE;
         beat_d  = '0;
         gap_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: note_d = NOTE_NONE;
            S_FETCH: begin
               if (song_end) begin
                  if (LOOP && step_q != '0) begin
                     step_d = '0;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = ~LOOP;
                  end
               end else begin
                  note_d  = note_clean(rom_note);
                  beat_d  = rom_dur;
                  state_d = S_HOLD;
               end
            end
            S_HOLD: begin
               if (!frozen && QUARTER_BEAT) begin
                  beat_d = beat_q - DUR_W'(1);
                  if (beat_q == DUR_W'(1)) begin
                     note_d  = NOTE_NONE;
                     gap_d   = GAP_W'(GAP_CYCLES - 1);
                     step_d  = step_q + ADDR_W'(1);
                     state_d = S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (!frozen) begin
                  if (gap_q == '0) state_d = S_FETCH;
                  else             gap_d   = gap_q - GAP_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         note_q  <= NOTE_NONE;
         beat_q  <= '0;
         gap_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         note_q  <= note_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         done_q  <= done_d;
      end
   end

   // note_q keeps the held note while paused; only the output is muted.
   assign note    = frozen ? NOTE_NONE : note_q;
   assign Led     = note_to_led(note);
   assign playing = (state_q != S_IDLE);
   assign done    = done_q;
   assign step    = step_q;

endmodule
